// File: rtl/uart_tx_if.sv
// uart_tx_if: store-side handshake between the memory unit and the UART
// transmitter.
//   load_uart     : one-cycle request to send data_to_uart (memory unit -> UART)
//   data_to_uart  : byte to send, sampled when the request is accepted
//   uart_busy     : a frame is currently on the line (UART -> memory unit)
//   uart_done     : one-cycle pulse after the stop bit completes
// modport master : memory-unit side
// modport slave  : transmitter side
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 load_uart;
   logic [DATA_BITS-1:0] data_to_uart;
   logic                 uart_busy;
   logic                 uart_done;

   modport master (
      output load_uart,
      output data_to_uart,
      input  uart_busy,
      input  uart_done
   );

   modport slave (
      input  load_uart,
      input  data_to_uart,
      output uart_busy,
      output uart_done
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter. Sends one byte per accepted request as
// start bit, DATA_BITS data bits (LSB first) and one stop bit. Each bit lasts
// CLKS_PER_BIT clocks. There is no queueing: a request is taken only in IDLE.
// After the stop bit, a single DONE cycle pulses uart_done. This guarantees
// at least one idle cycle before the next frame can be accepted.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : uart_tx_if slave (load_uart, data_to_uart in; uart_busy, uart_done out)
//   tx   : serial output, idle high
// All outputs come straight from flops.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for load_uart
// START | start bit (tx low) for CLKS_PER_BIT cycles
// DATA  | data bit [bit_idx], LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx high), busy still asserted
// DONE  | single cycle: busy low, done pulse, requests ignored
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic      clk,
   input  logic      rst,
   uart_tx_if.slave  bus,
   output logic      tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 bit_end;
   logic [IW-1:0]        idx_inc;

   assign bit_end = (cnt_q == CNT_LAST);
   assign idx_inc = idx_q + IW'(1);

   // tx is registered, so the level for the next bit is chosen one cycle
   // early, at the bit boundary, from the state being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (bus.load_uart) begin
               shift_d = bus.data_to_uart;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = idx_inc;
                  tx_d  = shift_q[idx_inc];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_DONE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            // Requests here are dropped on purpose; the memory unit only
            // issues loads when neither busy nor done is set.
            state_d = S_IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx            = tx_q;
   assign bus.uart_busy = busy_q;
   assign bus.uart_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   start_a, start_b;

   uart_tx_if #(.DATA_BITS(8)) bus ();

   uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .tx  (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, 32'(tx), 32'd1);
      check({tag, "_busy"}, 32'(bus.uart_busy), 32'd0);
      check({tag, "_done"}, 32'(bus.uart_done), 32'd0);
   endtask

   // Called at a negedge; leaves us at a negedge.
   task automatic expect_idle(input int n);
      for (int i = 0; i < n; i++) begin
         check_idle("idle");
         @(negedge clk);
      end
   endtask

   // Present a request during the current cycle; the next posedge takes it.
   // Data changes right after acceptance to prove it was captured.
   task automatic load_byte(input logic [7:0] d);
      bus.load_uart    = 1'b1;
      bus.data_to_uart = d;
      @(negedge clk);
      bus.load_uart    = 1'b0;
      bus.data_to_uart = 8'($urandom);
   endtask

   // Reference frame: line level at cycle c is bit c/CPB of {stop, data, start}.
   // Busy for 10*CPB cycles, then one done cycle, then idle.
   // poke_at >= 0 pulses a competing load at that cycle and in the done cycle.
   // abort_at >= 0 asserts rst at that cycle and returns after the reset edge.
   // Returns at the negedge of the first idle cycle after done.
   task automatic expect_frame(input logic [7:0] d, input int poke_at,
                               input int abort_at, output int start_cyc);
      logic [9:0] fr;
      fr = {1'b1, d, 1'b0};
      start_cyc = cyc;
      for (int c = 0; c < 10 * CPB + 2; c++) begin
         if (c < 10 * CPB) begin
            check("frame_tx", 32'(tx), 32'(fr[c / CPB]));
            check("frame_busy", 32'(bus.uart_busy), 32'd1);
            check("frame_done", 32'(bus.uart_done), 32'd0);
         end else if (c == 10 * CPB) begin
            check("done_tx", 32'(tx), 32'd1);
            check("done_busy", 32'(bus.uart_busy), 32'd0);
            check("done_pulse", 32'(bus.uart_done), 32'd1);
         end else begin
            check_idle("post_done");
         end
         if (c == abort_at) begin
            rst           = 1'b1;
            bus.load_uart = 1'b0;
            @(negedge clk);
            check_idle("abort");
            rst = 1'b0;
            return;
         end
         if (c < 10 * CPB + 1) begin
            bus.load_uart = (poke_at >= 0) && (c == poke_at || c == 10 * CPB);
            bus.data_to_uart = bus.load_uart ? 8'h3C : 8'($urandom);
            @(negedge clk);
         end
      end
      bus.load_uart = 1'b0;
   endtask

   initial begin
      int s;
      logic [7:0] rd;
      int gap, poke;

      bus.load_uart    = 1'b0;
      bus.data_to_uart = 8'h00;

      // reset held for three cycles, then quiet line
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("reset");
      end
      rst = 1'b0;
      @(negedge clk);
      expect_idle(20);

      // single frame
      load_byte(8'hA5);
      expect_frame(8'hA5, -1, -1, s);
      expect_idle(3);

      // extreme data values
      load_byte(8'h00);
      expect_frame(8'h00, -1, -1, s);
      load_byte(8'hFF);
      expect_frame(8'hFF, -1, -1, s);
      expect_idle(2);

      // competing loads mid-frame and in the done cycle are ignored
      load_byte(8'hA5);
      expect_frame(8'hA5, 10, -1, s);
      expect_idle(15);

      // back-to-back: second load in first idle cycle after done
      load_byte(8'h55);
      expect_frame(8'h55, -1, -1, start_a);
      load_byte(8'h81);
      expect_frame(8'h81, -1, -1, start_b);
      check("start_spacing", 32'(start_b - start_a), 32'(10 * CPB + 2));
      expect_idle(2);

      // reset during data bit 3, then a clean frame
      load_byte(8'h0F);
      expect_frame(8'h0F, -1, 4 * CPB + 1, s);
      expect_idle(20);
      load_byte(8'h12);
      expect_frame(8'h12, -1, -1, s);
      expect_idle(2);

      // reset and load in the same cycle: reset wins
      rst              = 1'b1;
      bus.load_uart    = 1'b1;
      bus.data_to_uart = 8'h6B;
      @(negedge clk);
      rst           = 1'b0;
      bus.load_uart = 1'b0;
      expect_idle(10);

      // random frames, random competing loads, random idle gaps
      for (int f = 0; f < 8; f++) begin
         rd   = 8'($urandom);
         gap  = int'($urandom_range(0, 3));
         poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 * CPB - 1)) : -1;
         load_byte(rd);
         expect_frame(rd, poke, -1, s);
         if (gap > 0) expect_idle(gap);
      end
      expect_idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
